// File: rtl/uart_telem_pkg.sv
// Shared definitions for the UART telemetry framer: FSM encoding, header marker,
// counter widths and the saturating increment used by the drop counter.
package uart_telem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [15:0] SYNC_DEFAULT = 16'hA5A5;
   localparam int          SEQ_W        = 16;
   localparam int          CNT_W        = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/uart_telem_scheduler_period_timer.sv
// Free-running frame timer: counts 0..PERIOD_CYCLES-1 while enabled and pulses
// tick for one cycle on the terminal count; disabled holds the count at 0.
module period_timer #(
   parameter int PERIOD_CYCLES = 120000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

   logic [CW-1:0] count;

   assign tick = enable && (count == CW'(PERIOD_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!enable || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_telem_scheduler.sv
// Periodic telemetry framer: snapshots N_CH channels on each timer tick and writes
// {header, ch0..chN-1} into the UART TX FIFO one word at a time, honouring FIFO full.
module uart_telem_scheduler
   import uart_telem_pkg::*;
#(
   parameter int          PERIOD_CYCLES = 120000,
   parameter int          N_CH          = 4,
   parameter int          WIDTH         = 32,
   parameter int          ADDR_W        = 9,
   parameter logic [15:0] SYNC          = SYNC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   input  logic [N_CH*WIDTH-1:0] i_ch_data,
   input  logic                  i_tx_full,
   output logic [WIDTH-1:0]      o_data,
   output logic [ADDR_W-1:0]     o_address,
   output logic                  o_wr_uart,
   output logic                  o_busy,
   output logic [SEQ_W-1:0]      o_seq,
   output logic [CNT_W-1:0]      o_overrun_cnt
);

   state_t                state;
   state_t                state_next;
   logic                  tick;
   logic [N_CH*WIDTH-1:0] snap;
   logic [ADDR_W-1:0]     idx;
   logic [SEQ_W-1:0]      seq;
   logic [CNT_W-1:0]      overrun_cnt;
   logic [WIDTH-1:0]      word;
   logic                  last_word;
   logic                  wr;
   logic [WIDTH-1:0]      data;
   logic [ADDR_W-1:0]     addr;

   period_timer #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .enable(i_enable),
      .tick  (tick)
   );

   assign last_word = (idx == ADDR_W'(N_CH));

   // Word 0 is the header carrying the sequence number; word k is snapshot channel k-1.
   always_comb begin
      state_next = state;
      word       = WIDTH'({SYNC, seq});
      for (int k = 0; k < N_CH; k++) begin
         if (idx == ADDR_W'(k + 1)) begin
            word = snap[k*WIDTH +: WIDTH];
         end
      end
      case (state)
         IDLE:    if (tick) state_next = ISSUE;
         ISSUE:   if (!i_tx_full) state_next = GAP;
         GAP:     state_next = last_word ? IDLE : ISSUE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         snap        <= '0;
         idx         <= '0;
         seq         <= '0;
         overrun_cnt <= '0;
         wr          <= 1'b0;
         data        <= '0;
         addr        <= '0;
      end else begin
         state <= state_next;
         wr    <= 1'b0;
         // A tick that arrives while a frame is still in flight is dropped and counted.
         if (tick && state != IDLE) begin
            overrun_cnt <= sat_inc(overrun_cnt);
         end
         case (state)
            IDLE: begin
               if (tick) begin
                  snap <= i_ch_data;
                  idx  <= '0;
               end
            end
            ISSUE: begin
               if (!i_tx_full) begin
                  wr   <= 1'b1;
                  data <= word;
                  addr <= idx;
               end
            end
            GAP: begin
               if (last_word) begin
                  seq <= seq + 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_wr_uart     = wr;
   assign o_data        = data;
   assign o_address     = addr;
   assign o_busy        = (state != IDLE);
   assign o_seq         = seq;
   assign o_overrun_cnt = overrun_cnt;

endmodule
